// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared segment encodings and scan FSM states for the seven-segment scanner.
package sevenseg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_INVALID = 8'hDB;
  localparam int SEG_DP_BIT = 7;
  typedef enum logic {BLANK, ON} scan_state_t;
  function automatic logic [7:0] seg_lookup(input logic [3:0] code);
    case (code)
      4'd0: seg_lookup = 8'hC0;
      4'd1: seg_lookup = 8'hF9;
      4'd2: seg_lookup = 8'hA4;
      4'd3: seg_lookup = 8'hB0;
      4'd4: seg_lookup = 8'h99;
      4'd5: seg_lookup = 8'h92;
      4'd6: seg_lookup = 8'h82;
      4'd7: seg_lookup = 8'hF8;
      4'd8: seg_lookup = 8'h80;
      4'd9: seg_lookup = 8'h90;
      default: seg_lookup = SEG_INVALID;
    endcase
  endfunction
endpackage

// File: rtl/sevenseg_digit_dec.sv
// sevenseg_digit_dec: BCD code plus dp plus blank to active-low segment pattern.
module sevenseg_digit_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  always_comb o_seg = i_blank ? SEG_BLANK : seg_lookup(i_code) & ~(8'(i_dp) << SEG_DP_BIT);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed common-anode display scanner with blanking guard,
// frame-aligned shadow commit and leading-zero suppression.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank_en,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  scan_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_val, r_disp_val;
  logic [NUM_DIGITS-1:0] r_sh_dp, r_disp_dp, r_an;
  logic r_sh_lz, r_disp_lz, r_pending, r_tick;
  logic [7:0] r_seg, w_seg;
  logic [3:0] w_code;
  logic w_slot_end, w_blank_end, w_commit, w_supp, w_on;
  assign w_slot_end = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_blank_end = r_cnt == CW'(BLANK_CYC - 1);
  assign w_on = r_state == ON;
  // a single-digit display has no last ON slot distinct from the first, so it commits as ON begins
  assign w_commit = NUM_DIGITS == 1 ? !w_on && w_blank_end
                                    : w_on && w_slot_end && r_idx == IW'(NUM_DIGITS - 1);
  assign w_code = r_disp_val[{r_idx, 2'b00} +: 4];
  assign w_supp = r_disp_lz && r_idx != '0 && (r_disp_val >> {r_idx, 2'b00}) == '0;
  always_comb w_state_nx = w_on ? (w_slot_end ? BLANK : ON) : (w_blank_end ? ON : BLANK);
  sevenseg_digit_dec u_dec (
    .i_code (w_code),
    .i_dp   (r_disp_dp[r_idx]),
    .i_blank(!w_on || w_supp),
    .o_seg  (w_seg)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_sh_lz    <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_lz  <= 1'b0;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
      r_seg      <= SEG_BLANK;
      r_an       <= '1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_on && w_slot_end)
        r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_sh_val <= value;
        r_sh_dp  <= dp_mask;
        r_sh_lz  <= lz_blank_en;
      end
      if (w_commit && load) begin
        r_disp_val <= value;
        r_disp_dp  <= dp_mask;
        r_disp_lz  <= lz_blank_en;
      end else if (w_commit && r_pending) begin
        r_disp_val <= r_sh_val;
        r_disp_dp  <= r_sh_dp;
        r_disp_lz  <= r_sh_lz;
      end
      r_pending <= !w_commit && (load || r_pending);
      r_tick    <= w_commit;
      r_seg     <= w_seg;
      r_an      <= w_on && !w_supp ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    end
  end
  assign pending = r_pending;
  assign frame_tick = r_tick;
  assign seg = r_seg;
  assign an = r_an;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed and random stimulus checked against a time-based display model.
module tb_sevenseg_scan_ctrl;
  localparam int N = 4, RD = 8, BC = 2;
  localparam logic [7:0] TBL [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic clk = 0, rst_n = 0, load = 0, lz_blank_en = 0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0] dp_mask = '0;
  logic pending, frame_tick;
  logic [7:0] seg;
  logic [N-1:0] an;
  int n_chk = 0, n_pass = 0;
  int m_t = 0, m_last = 0, rel = 0, first_on = -1, first_tick = -1;
  logic [15:0] m_dv, m_sv;
  logic [3:0] m_dd, m_sd, m_an;
  logic m_dl, m_sl, m_pend, m_tick;
  logic [7:0] m_seg;
  always #5 clk = ~clk;
  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
    .lz_blank_en(lz_blank_en), .pending(pending), .frame_tick(frame_tick), .seg(seg), .an(an)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic logic [7:0] dec7(input logic [3:0] c);
    return c < 4'd10 ? TBL[int'(c)] : 8'hDB;
  endfunction
  task automatic model();
    int dig, top;
    logic on, supp, cm;
    m_last = m_t;
    if (!rst_n) begin
      m_t = 0; m_dv = '0; m_sv = '0; m_dd = '0; m_sd = '0; m_dl = 0; m_sl = 0;
      m_pend = 0; m_tick = 0; m_seg = 8'hFF; m_an = 4'hF;
      return;
    end
    dig = (m_t / RD) % N;
    on = (m_t % RD) >= BC;
    top = 0;
    for (int i = 0; i < N; i++) if (m_dv[4*i +: 4] != 4'd0) top = i;
    supp = m_dl && dig > top;
    m_seg = (!on || supp) ? 8'hFF : dec7(m_dv[4*dig +: 4]) & (m_dd[dig] ? 8'h7F : 8'hFF);
    m_an = (on && !supp) ? ~(4'd1 << dig) : 4'hF;
    cm = (m_t % (N*RD)) == N*RD - 1;
    if (cm && load) begin
      m_dv = value; m_dd = dp_mask; m_dl = lz_blank_en;
      m_sv = value; m_sd = dp_mask; m_sl = lz_blank_en; m_pend = 0;
    end else if (cm) begin
      if (m_pend) begin m_dv = m_sv; m_dd = m_sd; m_dl = m_sl; end
      m_pend = 0;
    end else if (load) begin
      m_sv = value; m_sd = dp_mask; m_sl = lz_blank_en; m_pend = 1;
    end
    m_tick = cm;
    m_t++;
  endtask
  task automatic edge_chk();
    @(posedge clk);
    model();
    #1;
    rel = rst_n ? rel + 1 : 0;
    if (first_on < 0 && an !== 4'hF) first_on = rel;
    if (first_tick < 0 && frame_tick === 1'b1) first_tick = rel;
    chk("seg", {24'd0, seg}, {24'd0, m_seg});
    chk("an", {28'd0, an}, {28'd0, m_an});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
  endtask
  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic z);
    load = 1; value = v; dp_mask = d; lz_blank_en = z;
    edge_chk();
    load = 0;
  endtask
  task automatic wait_commit();
    logic seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      edge_chk();
      seen = frame_tick;
    end
    chk("commit_seen", {31'd0, seen}, 32'd1);
  endtask
  task automatic wait_t(input int ph);
    for (int i = 0; i < 64 && (m_t % (N*RD)) != ph; i++) edge_chk();
    chk("phase_reached", m_t % (N*RD), ph);
  endtask
  task automatic run_frame(input string tag, input logic [3:0] ea [4], input logic [7:0] es [4]);
    for (int i = 0; i < N*RD; i++) begin
      edge_chk();
      if (m_last % RD == 5) begin
        chk({tag, "_an"}, {28'd0, an}, {28'd0, ea[(m_last / RD) % N]});
        chk({tag, "_seg"}, {24'd0, seg}, {24'd0, es[(m_last / RD) % N]});
      end
    end
  endtask
  initial begin
    rst_n = 0;
    repeat (3) edge_chk();
    rst_n = 1;
    repeat (40) edge_chk();
    chk("first_on", first_on, 3);
    chk("first_tick", first_tick, 32);
    ld(16'h1234, 4'h0, 0);
    wait_commit();
    run_frame("scan", '{4'hE, 4'hD, 4'hB, 4'h7}, '{8'h99, 8'hB0, 8'hA4, 8'hF9});
    ld(16'h0070, 4'h0, 1);
    wait_commit();
    run_frame("lz70", '{4'hE, 4'hD, 4'hF, 4'hF}, '{8'hC0, 8'hF8, 8'hFF, 8'hFF});
    ld(16'h0000, 4'h0, 1);
    wait_commit();
    run_frame("lz00", '{4'hE, 4'hF, 4'hF, 4'hF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF});
    ld(16'h000A, 4'h1, 0);
    wait_commit();
    run_frame("inv", '{4'hE, 4'hD, 4'hB, 4'h7}, '{8'h5B, 8'hC0, 8'hC0, 8'hC0});
    ld(16'h1111, 4'h0, 0);
    repeat (3) edge_chk();
    ld(16'h2222, 4'h0, 0);
    chk("race_pend", {31'd0, pending}, 32'd1);
    wait_commit();
    run_frame("last_wins", '{4'hE, 4'hD, 4'hB, 4'h7}, '{8'hA4, 8'hA4, 8'hA4, 8'hA4});
    wait_t(N*RD - 1);
    ld(16'h3333, 4'h0, 0);
    chk("commit_load_pend", {31'd0, pending}, 32'd0);
    chk("commit_load_tick", {31'd0, frame_tick}, 32'd1);
    run_frame("direct", '{4'hE, 4'hD, 4'hB, 4'h7}, '{8'hB0, 8'hB0, 8'hB0, 8'hB0});
    ld(16'h5678, 4'h0, 0);
    wait_t(2*RD + 4);
    rst_n = 0;
    edge_chk();
    rst_n = 1;
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_pend", {31'd0, pending}, 32'd0);
    run_frame("restart", '{4'hE, 4'hD, 4'hB, 4'h7}, '{8'hC0, 8'hC0, 8'hC0, 8'hC0});
    for (int i = 0; i < 600; i++) begin
      load = $urandom_range(0, 7) == 0;
      value = 16'($urandom);
      dp_mask = 4'($urandom);
      lz_blank_en = 1'($urandom);
      rst_n = $urandom_range(0, 299) != 0;
      edge_chk();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexing scan controller for an NUM_DIGITS-digit common-anode seven-segment display. It holds a packed BCD value and sequences one shared segment decoder across the digits, driving active-low anode enables and active-low segment lines. A blanking guard at each digit switch prevents ghosting. New values are taken through a shadow register and committed only at frame boundaries, so a digit never shows a torn value. It sits between application logic (counters, status) and the board display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (blank and on time together).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off; 1 <= BLANK_CYC < REFRESH_DIV.
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; synchronous, active-low.
- load  in  1  single-cycle strobe; captures value, dp_mask and lz_blank_en into the shadow register.
- value  in  4*NUM_DIGITS  packed BCD; digit 0 (rightmost) = value[3:0].
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of that digit.
- lz_blank_en  in  1  1 = blank leading zero digits.
- pending  out  1  shadow holds an uncommitted load.
- frame_tick  out  1  one-cycle pulse on each frame commit.
- seg  out  8  active-low segments; bit 7 = dp, bits 6:0 = g..a.
- an  out  NUM_DIGITS  active-low anode enables; an[i] drives digit i.

## Operation
- Decode, active-low: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, codes A–F→DB. seg[7] is forced to 0 when the digit's dp bit is 1.
- Per-slot FSM:
  - BLANK: lasts BLANK_CYC cycles. an = all 1, seg = FF.
  - ON: lasts REFRESH_DIV-BLANK_CYC cycles. an[idx] = 0, seg = decode(digit idx).
  - After ON, control returns to BLANK and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Commit happens in the final ON cycle of digit NUM_DIGITS-1, or in the final BLANK→ON boundary when NUM_DIGITS=1.
  - If pending is 1, the shadow is copied into the display register and pending clears.
  - frame_tick pulses on every commit cycle, whether or not a load was pending.
- Load handling:
  - load sets pending and overwrites the shadow. If several loads arrive before a commit, the last one wins.
  - If load coincides with the commit cycle, the loaded data is committed directly and pending stays 0.
- Leading-zero blanking, when enabled:
  - Digit i is suppressed if it and every higher digit equal 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps an high in ON, with seg = FF, and its dp is also suppressed.
  - Codes A–F count as nonzero.
- Reset values: idx=0, state BLANK, slot counter 0, display/shadow registers 0, lz_blank_en shadow 0, pending=0, frame_tick=0, seg=FF, an=all 1.

## Timing
- seg and an are registered and lag the FSM state by 1 cycle.
- After reset release, the first ON appears on the outputs at cycle BLANK_CYC+1, on digit 0.
- Slot period = REFRESH_DIV cycles. Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- A committed value is first visible at the next digit-0 ON phase.
- Worst-case latency from load to display is about one frame plus BLANK_CYC.
- rst_n low on any clock edge, including mid-ON, forces all reset values on the next cycle and discards pending.
- The slot counter width is clog2(REFRESH_DIV). It counts 0..REFRESH_DIV-1 and wraps with no skipped or extra cycles.

## Structure
- Shared package sevenseg_pkg holds:
  - segment encoding constants: SEG_BLANK=FF, SEG_INVALID=DB, SEG_DP_BIT=7, the 0–9 table;
  - the FSM state enum {BLANK, ON}.
- Sub-module sevenseg_digit_dec: combinational 4-bit code plus dp plus blank → 8-bit active-low segments. It is instantiated once and shared by the scanner.
- The top level holds the FSM, slot counter, digit index, shadow/display registers, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset:
  - Hold rst_n=0 for 3 cycles, then release → seg=FF, an=1111 for 2 cycles.
  - Then an=1110, seg=C0 for 6 cycles, and frame_tick first at cycle 32.
- Scan order: load 0x1234, wait for commit → per slot:
  - an=1110, seg=99;
  - an=1101, seg=B0;
  - an=1011, seg=A4;
  - an=0111, seg=F9;
  - always BLANK (FF/1111) between slots.
- Leading-zero blanking with lz_blank_en=1:
  - value 0x0070 → digits 3 and 2 keep an high; digit 1 seg=F8; digit 0 seg=C0.
  - value 0x0000 → only digit 0 lights, seg=C0.
- Invalid code with dp: value 0x000A, dp_mask=0001, lz off → digit 0 seg=5B; digits 1–3 seg=C0.
- Load races:
  - load 0x1111, then 0x2222 within the same frame → only 2222 is displayed; pending=1 until the commit.
  - load 0x3333 exactly on the commit cycle → committed that frame; pending stays 0.
- Mid-frame reset: rst_n=0 for 1 cycle during the digit-2 ON phase → next cycle seg=FF, an=1111, pending=0, display=0; the scan restarts from digit 0.
